// File: rtl/input_spike_buffer_if.sv
// input_spike_buffer_if: push/pop handshake bundle between the host side and the core grid.
interface input_spike_buffer_if #(
    parameter int DATA_W = 30
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (output wr_en, output wr_data, output rd_ready,
                    input full, input rd_valid, input rd_data);
    modport slave  (input wr_en, input wr_data, input rd_ready,
                    output full, output rd_valid, output rd_data);
endinterface

// File: rtl/input_spike_buffer.sv
// input_spike_buffer: FWFT spike FIFO plus IDLE/RUN/DONE tick-run FSM; INPUT_SPIKE_BUFFER_DROP_CNT_EN adds drop_cnt.
module input_spike_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 30,
    parameter int TICK_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input_spike_buffer_if.slave      bus,
    output logic                     input_buffer_empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     tick,
    input  logic [TICK_W-1:0]        num_ticks,
    input  logic                     start,
    output logic                     complete,
    output logic [TICK_W-1:0]        tick_cnt
`ifdef INPUT_SPIKE_BUFFER_DROP_CNT_EN
    ,output logic [15:0]             drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              push, pop;
    state_t            state;

    assign input_buffer_empty = wr_ptr == rd_ptr;
    assign bus.full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count        = wr_ptr - rd_ptr;
    assign bus.rd_valid = !input_buffer_empty;
    assign bus.rd_data  = mem[rd_ptr[AW-1:0]];
    assign push         = bus.wr_en && !bus.full;
    assign pop          = bus.rd_valid && bus.rd_ready;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end

    // completion needs both the tick budget met and the buffer drained
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            complete <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    tick_cnt <= '0;
                end
                RUN: if (start) begin
                    tick_cnt <= '0;
                end else begin
                    if (tick && tick_cnt != '1) tick_cnt <= tick_cnt + TICK_W'(1);
                    if (tick_cnt == num_ticks && num_ticks != '0 && input_buffer_empty) begin
                        state    <= DONE;
                        complete <= 1'b1;
                    end
                end
                DONE: if (start) begin
                    state    <= RUN;
                    tick_cnt <= '0;
                    complete <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end

`ifdef INPUT_SPIKE_BUFFER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            drop_cnt <= '0;
        else if (start)
            drop_cnt <= '0;
        else if (bus.wr_en && bus.full && drop_cnt != '1)
            drop_cnt <= drop_cnt + 16'd1;
`endif
endmodule
